// File: rtl/wb_cmd_master.sv
// Wishbone classic master fed by a valid/ready command port; one response per command.
// Registered bus/response outputs, single outstanding transaction, optional ACK timeout.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] cnt;
  logic            accept, ack_hit, to_hit, rsp_done;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        // ACK takes priority over a timeout landing in the same cycle
        if (wbm_ack_i) begin
          ack_hit   = 1'b1;
          state_nxt = RESP;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          to_hit    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wbm_we_o  <= cmd_we;
        wbm_adr_o <= cmd_adr;
        wbm_dat_o <= cmd_dat;
        wbm_sel_o <= cmd_sel;
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        cnt       <= '0;
      end
      if (ack_hit) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_dat     <= wbm_we_o ? 32'h0 : wbm_dat_i;
        rsp_timeout <= 1'b0;
        rsp_valid   <= 1'b1;
      end else if (to_hit) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_dat     <= 32'h0;
        rsp_timeout <= 1'b1;
        rsp_valid   <= 1'b1;
      end else if (state == BUS) begin
        cnt <= cnt + 1'b1;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized bench for wb_cmd_master with a transaction-level expectation model.
module tb_wb_cmd_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic        ack;
  logic [31:0] dat_i;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(TO), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_timeout(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we_o), .wbm_sel_o(sel_o),
    .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // delay = STB cycles before ACK (0 = ACK on first STB cycle), -1 = never ACK
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int delay, input logic [31:0] rdata,
                     input int hold);
    int          stb_cycles, exp_stb, guard;
    bit          exp_to;
    logic [31:0] exp_dat, first_dat;

    exp_to  = !(delay >= 0 && delay + 1 <= TO);
    exp_stb = exp_to ? TO : delay + 1;
    exp_dat = (!w && !exp_to) ? rdata : 32'h0;

    check("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
    cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
    step();
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom;
    check("stb_start", {30'h0, cyc, stb}, 32'h3);
    check("wbm_we", {31'h0, we_o}, {31'h0, w});
    check("wbm_adr", adr_o, a);
    check("wbm_dat", dat_o, d);
    check("wbm_sel", {28'h0, sel_o}, {28'h0, s});
    check("busy_bus", {31'h0, busy}, 32'h1);

    stb_cycles = 0;
    guard      = 0;
    while (stb && guard < 64) begin
      stb_cycles++;
      guard++;
      ack   = (stb_cycles == delay + 1);
      dat_i = ack ? rdata : $urandom;
      if (adr_o !== a) check("adr_stable", adr_o, a);
      step();
    end
    ack = 1'b0;
    check("stb_cycles", stb_cycles, exp_stb);
    check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, exp_to});
    check("rsp_dat", rsp_dat, exp_dat);

    first_dat = rsp_dat;
    cmd_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_valid", {31'h0, rsp_valid}, 32'h1);
      check("hold_dat", rsp_dat, first_dat);
      check("hold_no_accept", {30'h0, cmd_ready, stb}, 32'h0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_drop", {31'h0, rsp_valid}, 32'h0);
    check("post_idle", {29'h0, cmd_ready, stb, busy}, 32'h4);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
    rsp_ready = 0; ack = 0; dat_i = 0;
    step(); step();
    rst = 1'b0;
    check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check("rst_bus", {29'h0, cyc, stb, we_o}, 32'h0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_rsp", {30'h0, rsp_valid, rsp_timeout}, 32'h0);
    check("rst_rsp_dat", rsp_dat, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);

    txn(1'b0, 32'h3000_0004, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 0);
    txn(1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 0, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 32'hAAAA_5555, 0);
    txn(1'b0, 32'h3000_000C, 32'h0, 4'h3, 7, 32'hCAFE_F00D, 0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'h0BAD_C0DE, 5);

    // reset mid-transaction
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
    step();
    cmd_valid = 1'b0;
    check("midrst_stb", {31'h0, stb}, 32'h1);
    rst = 1'b1;
    step();
    check("midrst_drop", {30'h0, cyc, stb}, 32'h0);
    check("midrst_rsp", {31'h0, rsp_valid}, 32'h0);
    rst = 1'b0;
    step();
    check("midrst_ready", {31'h0, cmd_ready}, 32'h1);
    ack = 1'b1; dat_i = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stray_ack", {29'h0, rsp_valid, stb, busy}, 32'h0);
    end
    ack = 1'b0;

    for (int n = 0; n < 40; n++) begin
      int d;
      d = $urandom_range(0, 10);
      if (d == 10) d = -1;
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), d, $urandom,
          $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
